// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types, default 640x480@60 geometry and axis sizing helpers.
// Purely declarative: no latency, no flow control.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } t_phase;

    localparam int c_DEF_H_ACTIVE = 640;
    localparam int c_DEF_H_FRONT  = 16;
    localparam int c_DEF_H_SYNC   = 96;
    localparam int c_DEF_H_BACK   = 48;
    localparam int c_DEF_V_ACTIVE = 480;
    localparam int c_DEF_V_FRONT  = 10;
    localparam int c_DEF_V_SYNC   = 2;
    localparam int c_DEF_V_BACK   = 33;

    function automatic int axis_total(input int a, input int f, input int s, input int b);
        return a + f + s + b;
    endfunction

    function automatic int axis_width(input int a, input int f, input int s, input int b);
        return $clog2(axis_total(a, f, s, b));
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: phase FSM plus in-phase and absolute counters; 1-clock registered update.
// No backpressure: state holds whenever i_Step is 0.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   g_Active   = c_DEF_H_ACTIVE,
    parameter int   g_Front    = c_DEF_H_FRONT,
    parameter int   g_Sync     = c_DEF_H_SYNC,
    parameter int   g_Back     = c_DEF_H_BACK,
    parameter logic g_Sync_Pol = 1'b0,
    localparam int  c_W        = axis_width(g_Active, g_Front, g_Sync, g_Back)
) (
    input  logic           i_Clk,
    input  logic           i_Reset,
    input  logic           i_Step,
    output logic [c_W-1:0] o_Pos,
    output t_phase         o_Phase,
    output logic           o_Sync,
    output logic           o_Wrap
);

    if (g_Active < 1 || g_Front < 1 || g_Sync < 1 || g_Back < 1) begin : g_bad_geometry
        $error("vga_axis_counter: every phase length must be at least 1");
    end

    localparam int             c_Total    = axis_total(g_Active, g_Front, g_Sync, g_Back);
    localparam logic [c_W-1:0] c_Last     = c_W'(c_Total - 1);
    localparam logic [c_W-1:0] c_Act_Last = c_W'(g_Active - 1);
    localparam logic [c_W-1:0] c_Frt_Last = c_W'(g_Front - 1);
    localparam logic [c_W-1:0] c_Syn_Last = c_W'(g_Sync - 1);
    localparam logic [c_W-1:0] c_Bck_Last = c_W'(g_Back - 1);

    t_phase         phase_q, phase_d;
    logic [c_W-1:0] cnt_q, cnt_d;
    logic [c_W-1:0] pos_q, pos_d;
    logic           sync_q, sync_d;
    logic [c_W-1:0] phase_last;

    always_comb begin
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        pos_d      = pos_q;
        phase_last = c_Act_Last;
        case (phase_q)
            FRONT:   phase_last = c_Frt_Last;
            SYNC:    phase_last = c_Syn_Last;
            BACK:    phase_last = c_Bck_Last;
            default: phase_last = c_Act_Last;
        endcase

        if (i_Step) begin
            pos_d = (pos_q == c_Last) ? '0 : pos_q + 1'b1;
            if (cnt_q == phase_last) begin
                cnt_d   = '0;
                // BACK + 1 wraps to ACTIVE in the 2-bit encoding
                phase_d = t_phase'(phase_q + 2'd1);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        sync_d = (phase_d == SYNC) ? g_Sync_Pol : ~g_Sync_Pol;
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            phase_q <= ACTIVE;
            cnt_q   <= '0;
            pos_q   <= '0;
            sync_q  <= ~g_Sync_Pol;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            sync_q  <= sync_d;
        end
    end

    assign o_Pos   = pos_q;
    assign o_Phase = phase_q;
    assign o_Sync  = sync_q;
    assign o_Wrap  = (pos_q == c_Last);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator advancing on i_Pix_En; all flags registered, 1-clock latency.
// No backpressure: position and levels hold while i_Pix_En is 0, pulses drop to 0.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   g_H_Active  = c_DEF_H_ACTIVE,
    parameter int   g_H_Front   = c_DEF_H_FRONT,
    parameter int   g_H_Sync    = c_DEF_H_SYNC,
    parameter int   g_H_Back    = c_DEF_H_BACK,
    parameter int   g_V_Active  = c_DEF_V_ACTIVE,
    parameter int   g_V_Front   = c_DEF_V_FRONT,
    parameter int   g_V_Sync    = c_DEF_V_SYNC,
    parameter int   g_V_Back    = c_DEF_V_BACK,
    parameter logic g_HSync_Pol = 1'b0,
    parameter logic g_VSync_Pol = 1'b0,
    localparam int  c_Col_W     = axis_width(g_H_Active, g_H_Front, g_H_Sync, g_H_Back),
    localparam int  c_Row_W     = axis_width(g_V_Active, g_V_Front, g_V_Sync, g_V_Back)
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Pix_En,
    output logic [c_Col_W-1:0] o_Col,
    output logic [c_Row_W-1:0] o_Row,
    output logic               o_HSync,
    output logic               o_VSync,
    output logic               o_Active,
    output logic               o_Line_Start,
    output logic               o_Frame_Start
);

    t_phase h_phase, v_phase;
    logic   h_wrap, v_wrap;
    logic   v_step;
    logic   line_start_q, line_start_d;
    logic   frame_start_q, frame_start_d;

    // Row advances on the same edge the column wraps H-1 -> 0
    assign v_step = i_Pix_En & h_wrap;

    vga_axis_counter #(
        .g_Active   (g_H_Active),
        .g_Front    (g_H_Front),
        .g_Sync     (g_H_Sync),
        .g_Back     (g_H_Back),
        .g_Sync_Pol (g_HSync_Pol)
    ) u_h_axis (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Step  (i_Pix_En),
        .o_Pos   (o_Col),
        .o_Phase (h_phase),
        .o_Sync  (o_HSync),
        .o_Wrap  (h_wrap)
    );

    vga_axis_counter #(
        .g_Active   (g_V_Active),
        .g_Front    (g_V_Front),
        .g_Sync     (g_V_Sync),
        .g_Back     (g_V_Back),
        .g_Sync_Pol (g_VSync_Pol)
    ) u_v_axis (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Step  (v_step),
        .o_Pos   (o_Row),
        .o_Phase (v_phase),
        .o_Sync  (o_VSync),
        .o_Wrap  (v_wrap)
    );

    always_comb begin
        line_start_d  = v_step;
        frame_start_d = v_step & v_wrap;
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_Active      = (h_phase == ACTIVE) && (v_phase == ACTIVE);
    assign o_Line_Start  = line_start_q;
    assign o_Frame_Start = frame_start_q;

endmodule
